// File: rtl/wav_burst_writer.sv
// wav_burst_writer
// Buffers 16-bit audio samples from the ADC capture stage in a FIFO and
// drains them to the DDR/SDRAM write port as fixed-length bursts. The
// bursts walk a circular address window [START_ADDR, END_ADDR].
//
// Ports:
//   clock_50M, reset_n   clock (rising edge) and async active-low reset
//   record_en            level enable for sample capture
//   wav_in_data/wav_wren sample input, qualified by a one-clock strobe
//   mem_wr_req/addr/ack  burst request handshake
//   mem_wr_data_req/data word pull; data valid the cycle after the pull
//   mem_wr_done          burst committed
//   fifo_level           FIFO occupancy
//   overflow, wrap_flag  sticky status, cleared on a record_en rising edge
//   busy                 FSM is not idle
module wav_burst_writer #(
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 64,
  parameter int                BURST_LEN  = 8,
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] START_ADDR = 24'h000000,
  parameter logic [ADDR_W-1:0] END_ADDR   = 24'h0FFFFF
) (
  input  logic                          clock_50M,
  input  logic                          reset_n,
  input  logic                          record_en,
  input  logic [DATA_W-1:0]             wav_in_data,
  input  logic                          wav_wren,
  output logic                          mem_wr_req,
  output logic [ADDR_W-1:0]             mem_wr_addr,
  input  logic                          mem_wr_ack,
  input  logic                          mem_wr_data_req,
  output logic [DATA_W-1:0]             mem_wr_data,
  input  logic                          mem_wr_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          wrap_flag,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_WAIT_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                overflow_q, overflow_d;
  logic                wrap_q, wrap_d;
  logic                rec_en_q;
  logic                reload_q, reload_d;
  logic                flush_q, flush_d;

  logic                fifo_full, fifo_empty;
  logic                push_req, push_ok, data_take, pop;
  logic                rec_rise, rec_fall, launch, burst_last, done_take;
  logic [ADDR_W:0]     addr_sum;
  logic                wrap_now;

  // Handshake qualification and FIFO flags. Full is judged on the current
  // occupancy, so a same-cycle pop never rescues a push into a full FIFO.
  always_comb begin
    fifo_full  = (count_q == LVL_W'(FIFO_DEPTH));
    fifo_empty = (count_q == '0);
    push_req   = wav_wren & record_en;
    push_ok    = push_req & ~fifo_full;
    data_take  = (state_q == S_DATA) & mem_wr_data_req;
    pop        = data_take & ~fifo_empty;
    done_take  = (state_q == S_WAIT_DONE) & mem_wr_done;
    rec_rise   = record_en & ~rec_en_q;
    rec_fall   = ~record_en & rec_en_q;
    launch     = (state_q == S_IDLE) &&
                 ((count_q >= LVL_W'(BURST_LEN)) || (flush_q && !fifo_empty));
    burst_last = data_take && (word_cnt_q == CNT_W'(BURST_LEN - 1));
    // One extra bit so the end-of-window test cannot itself overflow.
    addr_sum   = {1'b0, addr_q} + (ADDR_W+1)'(BURST_LEN);
    wrap_now   = (addr_sum > {1'b0, END_ADDR});
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (launch)      state_d = S_REQ;
      S_REQ:       if (mem_wr_ack)  state_d = S_DATA;
      S_DATA:      if (burst_last)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (mem_wr_done) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // FSM outputs are decoded from the state so they drop with reset at once.
  always_comb begin
    mem_wr_req = (state_q == S_REQ);
    busy       = (state_q != S_IDLE);
  end

  // Datapath next values: FIFO pointers, burst address, status flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    addr_d     = addr_q;
    data_d     = '0;
    overflow_d = overflow_q;
    wrap_d     = wrap_q;
    reload_d   = reload_q;
    flush_d    = flush_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    if (rec_rise) begin
      overflow_d = 1'b0;
      wrap_d     = 1'b0;
      reload_d   = 1'b1;
    end
    if (push_req && fifo_full) overflow_d = 1'b1;

    if (rec_fall && !fifo_empty && (count_q < LVL_W'(BURST_LEN))) flush_d = 1'b1;

    // A reload requested in the same cycle as the launch still applies.
    if (launch) begin
      if (reload_q || rec_rise) addr_d = START_ADDR;
      reload_d = 1'b0;
      flush_d  = 1'b0;
    end

    if (state_q == S_REQ) word_cnt_d = '0;
    if (data_take) begin
      word_cnt_d = word_cnt_q + 1'b1;
      // An empty FIFO during a burst only happens on a flush: pad with zero.
      if (!fifo_empty) data_d = fifo_mem_q[rd_ptr_q];
    end

    if (done_take) begin
      if (wrap_now) begin
        addr_d = START_ADDR;
        wrap_d = 1'b1;
      end else begin
        addr_d = addr_sum[ADDR_W-1:0];
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      addr_q     <= START_ADDR;
      data_q     <= '0;
      overflow_q <= 1'b0;
      wrap_q     <= 1'b0;
      rec_en_q   <= 1'b0;
      reload_q   <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      wrap_q     <= wrap_d;
      rec_en_q   <= record_en;
      reload_q   <= reload_d;
      flush_q    <= flush_d;
    end
  end

  // Sample storage; contents are meaningless once the pointers reset.
  always_ff @(posedge clock_50M) begin
    if (push_ok) fifo_mem_q[wr_ptr_q] <= wav_in_data;
  end

  assign mem_wr_addr = addr_q;
  assign mem_wr_data = data_q;
  assign fifo_level  = count_q;
  assign overflow    = overflow_q;
  assign wrap_flag   = wrap_q;

endmodule

// File: tb/tb_wav_burst_writer.sv
// Directed self-checking bench for wav_burst_writer. A second instance with
// a 16-word window shares all stimulus and exercises the address wrap.
module tb_wav_burst_writer;

  logic        clock_50M = 1'b0;
  logic        reset_n;
  logic        record_en;
  logic [15:0] wav_in_data;
  logic        wav_wren;
  logic        mem_wr_ack;
  logic        mem_wr_data_req;
  logic        mem_wr_done;

  logic        mem_wr_req, w_req;
  logic [23:0] mem_wr_addr, w_addr;
  logic [15:0] mem_wr_data, w_data;
  logic [6:0]  fifo_level, w_level;
  logic        overflow, w_overflow;
  logic        wrap_flag, w_wrap_flag;
  logic        busy, w_busy;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_words [8];

  wav_burst_writer u_dut (
    .clock_50M(clock_50M), .reset_n(reset_n), .record_en(record_en),
    .wav_in_data(wav_in_data), .wav_wren(wav_wren),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_ack(mem_wr_ack),
    .mem_wr_data_req(mem_wr_data_req), .mem_wr_data(mem_wr_data),
    .mem_wr_done(mem_wr_done), .fifo_level(fifo_level), .overflow(overflow),
    .wrap_flag(wrap_flag), .busy(busy)
  );

  wav_burst_writer #(.END_ADDR(24'h00000F)) u_wrap (
    .clock_50M(clock_50M), .reset_n(reset_n), .record_en(record_en),
    .wav_in_data(wav_in_data), .wav_wren(wav_wren),
    .mem_wr_req(w_req), .mem_wr_addr(w_addr), .mem_wr_ack(mem_wr_ack),
    .mem_wr_data_req(mem_wr_data_req), .mem_wr_data(w_data),
    .mem_wr_done(mem_wr_done), .fifo_level(w_level), .overflow(w_overflow),
    .wrap_flag(w_wrap_flag), .busy(w_busy)
  );

  // 50 MHz clock.
  always #10 clock_50M = ~clock_50M;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock_50M);
  endtask

  // One wav_wren pulse followed by idle cycles up to the given spacing.
  task automatic applyStimulus(input logic [15:0] d, input int gap);
    wav_wren    = 1'b1;
    wav_in_data = d;
    @(negedge clock_50M);
    wav_wren    = 1'b0;
    tick(gap - 1);
  endtask

  // Bounded wait for a burst request.
  task automatic waitReq(input string tag);
    int n = 0;
    while (!mem_wr_req && n < 3000) begin
      @(negedge clock_50M);
      n++;
    end
    checkOutput({tag, "_req"}, 32'(mem_wr_req), 32'd1);
  endtask

  // Full burst: request, ack, eight word pulls (optionally with one
  // concurrent sample push), one excess pull, done.
  task automatic runBurst(input string tag, input logic [23:0] exp_addr,
                          input logic [23:0] exp_waddr, input int push_idx,
                          input logic [15:0] push_val, input int exp_lvl);
    waitReq(tag);
    checkOutput({tag, "_addr"}, 32'(mem_wr_addr), 32'(exp_addr));
    checkOutput({tag, "_waddr"}, 32'(w_addr), 32'(exp_waddr));
    mem_wr_ack = 1'b1;
    @(negedge clock_50M);
    mem_wr_ack = 1'b0;
    checkOutput({tag, "_req_drop"}, 32'(mem_wr_req), 32'd0);
    for (int k = 0; k < 8; k++) begin
      mem_wr_data_req = 1'b1;
      if (k == push_idx) begin
        wav_wren    = 1'b1;
        wav_in_data = push_val;
      end
      @(negedge clock_50M);
      wav_wren = 1'b0;
      checkOutput($sformatf("%s_w%0d", tag, k), 32'(mem_wr_data), 32'(exp_words[k]));
      if (k == push_idx)
        checkOutput({tag, "_lvl_push_pop"}, 32'(fifo_level), 32'(exp_lvl));
    end
    @(negedge clock_50M);
    checkOutput({tag, "_excess_zero"}, 32'(mem_wr_data), 32'd0);
    checkOutput({tag, "_busy_wait"}, 32'(busy), 32'd1);
    mem_wr_data_req = 1'b0;
    mem_wr_done     = 1'b1;
    @(negedge clock_50M);
    mem_wr_done = 1'b0;
    checkOutput({tag, "_busy_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n         = 1'b0;
    record_en       = 1'b0;
    wav_in_data     = '0;
    wav_wren        = 1'b0;
    mem_wr_ack      = 1'b0;
    mem_wr_data_req = 1'b0;
    mem_wr_done     = 1'b0;
    tick(3);

    // Reset values.
    checkOutput("rst_req", 32'(mem_wr_req), 32'd0);
    checkOutput("rst_addr", 32'(mem_wr_addr), 32'd0);
    checkOutput("rst_data", 32'(mem_wr_data), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_wrap", 32'(wrap_flag), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Eight slow samples form the first burst at START_ADDR.
    record_en = 1'b1;
    tick(2);
    for (int i = 1; i <= 7; i++) applyStimulus(16'(i), 1042);
    checkOutput("seven_level", 32'(fifo_level), 32'd7);
    checkOutput("seven_no_req", 32'(mem_wr_req), 32'd0);
    applyStimulus(16'd8, 1042);
    for (int k = 0; k < 8; k++) exp_words[k] = 16'(k + 1);
    runBurst("b1", 24'h000000, 24'h000000, -1, 16'h0, 0);
    checkOutput("b1_next_addr", 32'(mem_wr_addr), 32'h000008);
    checkOutput("b1_level", 32'(fifo_level), 32'd0);

    // Partial burst flushed and zero-padded when recording stops.
    applyStimulus(16'h000A, 2);
    applyStimulus(16'h000B, 2);
    applyStimulus(16'h000C, 2);
    checkOutput("flush_level3", 32'(fifo_level), 32'd3);
    record_en = 1'b0;
    exp_words[0] = 16'h000A;
    exp_words[1] = 16'h000B;
    exp_words[2] = 16'h000C;
    for (int k = 3; k < 8; k++) exp_words[k] = 16'h0000;
    runBurst("flush", 24'h000008, 24'h000008, -1, 16'h0, 0);
    checkOutput("flush_level0", 32'(fifo_level), 32'd0);
    checkOutput("flush_next_addr", 32'(mem_wr_addr), 32'h000010);
    checkOutput("wrapdut_addr0", 32'(w_addr), 32'h000000);
    checkOutput("wrapdut_flag_set", 32'(w_wrap_flag), 32'd1);
    checkOutput("main_no_wrap", 32'(wrap_flag), 32'd0);

    // Overflow: 65 samples with the request left unacknowledged.
    record_en = 1'b1;
    tick(2);
    checkOutput("rise_clears_wrap", 32'(w_wrap_flag), 32'd0);
    for (int i = 0; i < 65; i++) applyStimulus(16'h0100 + 16'(i), 2);
    checkOutput("ovf_level", 32'(fifo_level), 32'd64);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_req_held", 32'(mem_wr_req), 32'd1);
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 8; k++) exp_words[k] = 16'h0100 + 16'(b * 8 + k);
      runBurst($sformatf("drain%0d", b), 24'(b * 8), 24'((b % 2) * 8), -1, 16'h0, 0);
    end
    tick(3);
    checkOutput("drain_level0", 32'(fifo_level), 32'd0);
    checkOutput("drain_no_req", 32'(mem_wr_req), 32'd0);
    checkOutput("drain_wrap_set", 32'(w_wrap_flag), 32'd1);
    record_en = 1'b0;
    tick(2);
    record_en = 1'b1;
    tick(2);
    checkOutput("ovf_cleared", 32'(overflow), 32'd0);
    checkOutput("wrap_cleared", 32'(w_wrap_flag), 32'd0);

    // Reset in the middle of the data phase.
    for (int i = 0; i < 8; i++) applyStimulus(16'h0200 + 16'(i), 2);
    waitReq("mid");
    checkOutput("mid_addr_reload", 32'(mem_wr_addr), 32'h000000);
    mem_wr_ack = 1'b1;
    @(negedge clock_50M);
    mem_wr_ack = 1'b0;
    mem_wr_data_req = 1'b1;
    tick(4);
    mem_wr_data_req = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_req", 32'(mem_wr_req), 32'd0);
    checkOutput("mid_rst_level", 32'(fifo_level), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int i = 0; i < 8; i++) applyStimulus(16'h0300 + 16'(i), 2);
    for (int k = 0; k < 8; k++) exp_words[k] = 16'h0300 + 16'(k);
    runBurst("post_rst", 24'h000000, 24'h000000, -1, 16'h0, 0);

    // Push and pop in the same cycle with nine samples queued.
    for (int i = 0; i < 9; i++) applyStimulus(16'h0400 + 16'(i), 2);
    checkOutput("same_level9", 32'(fifo_level), 32'd9);
    for (int k = 0; k < 8; k++) exp_words[k] = 16'h0400 + 16'(k);
    runBurst("same", 24'h000008, 24'h000008, 0, 16'h04AA, 9);
    checkOutput("same_level2", 32'(fifo_level), 32'd2);
    for (int i = 0; i < 6; i++) applyStimulus(16'h0410 + 16'(i), 2);
    exp_words[0] = 16'h0408;
    exp_words[1] = 16'h04AA;
    for (int k = 2; k < 8; k++) exp_words[k] = 16'h0410 + 16'(k - 2);
    runBurst("order", 24'h000010, 24'h000000, -1, 16'h0, 0);
    checkOutput("final_level", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
